// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared constants and state encoding for the id/ex pipeline register
package id_ex_reg_pkg;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0]  ZERO_REG  = 5'h0;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/id_ex_reg_dff.sv
// pipe_dff: width-parameterised flop with sync active-low reset to a default and hold enable
module pipe_dff #(
  parameter int W = 32,
  parameter logic [W-1:0] DEF = '0
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= DEF;
    else if (!hold) q <= d;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register with hold, multi-cycle flush and bubble counter
module id_ex_reg import id_ex_reg_pkg::*; #(
  parameter int FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_INST = NOP_WORD,
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             reg_wen_i,
  input  logic             hold_flag_i,
  input  logic             jump_en_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      op1_o,
  output logic [31:0]      op2_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_wen_o,
  output logic             valid_o,
  output logic             flushing_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
    $error("FLUSH_CYCLES must be in 1..7");
  end
  state_t state, state_n;
  logic [2:0] fcnt, fcnt_n;
  logic bubble, hold;
  always_comb begin
    bubble  = jump_en_i || state == FLUSH;
    hold    = !bubble && hold_flag_i;
    state_n = jump_en_i ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
              state == FLUSH ? (fcnt == 3'd1 ? RUN : FLUSH) :
              hold_flag_i ? HOLD : RUN;
    fcnt_n  = jump_en_i ? 3'(FLUSH_CYCLES - 1) : state == FLUSH ? fcnt - 3'd1 : fcnt;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state        <= RUN;
      fcnt         <= '0;
      bubble_cnt_o <= '0;
    end else begin
      state        <= state_n;
      fcnt         <= fcnt_n;
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(bubble);
    end
  assign flushing_o = state == FLUSH;
  pipe_dff #(.W(32), .DEF(NOP_INST)) u_inst (
    .clk(clk), .rst(rst), .hold(hold), .d(bubble ? NOP_INST : inst_i), .q(inst_o));
  pipe_dff #(.W(32), .DEF(ZERO_WORD)) u_addr (
    .clk(clk), .rst(rst), .hold(hold), .d(bubble ? ZERO_WORD : inst_addr_i), .q(inst_addr_o));
  pipe_dff #(.W(32), .DEF(ZERO_WORD)) u_op1 (
    .clk(clk), .rst(rst), .hold(hold), .d(bubble ? ZERO_WORD : op1_i), .q(op1_o));
  pipe_dff #(.W(32), .DEF(ZERO_WORD)) u_op2 (
    .clk(clk), .rst(rst), .hold(hold), .d(bubble ? ZERO_WORD : op2_i), .q(op2_o));
  pipe_dff #(.W(5), .DEF(ZERO_REG)) u_rd (
    .clk(clk), .rst(rst), .hold(hold), .d(bubble ? ZERO_REG : rd_addr_i), .q(rd_addr_o));
  pipe_dff #(.W(1), .DEF(1'b0)) u_wen (
    .clk(clk), .rst(rst), .hold(hold), .d(!bubble && reg_wen_i), .q(reg_wen_o));
  pipe_dff #(.W(1), .DEF(1'b0)) u_valid (
    .clk(clk), .rst(rst), .hold(hold), .d(!bubble), .q(valid_o));
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: table-driven and randomized model-checked bench for id_ex_reg
module tb_id_ex_reg;
  localparam logic [31:0] N = 32'h13;
  localparam logic [31:0] A = 32'h00A00113, B = 32'h00B00193, C = 32'h00C00213;
  localparam logic [31:0] D = 32'h00D00293, E = 32'h00E00313;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, jump, hold, wen;
  logic [31:0] inst, addr, op1, op2;
  logic [4:0] rd;
  logic [31:0] inst_o[3], addr_o[3], op1_o[3], op2_o[3];
  logic [4:0] rd_o[3];
  logic wen_o[3], valid_o[3], fl_o[3];
  logic [15:0] b0, b1;
  logic [3:0] b2;
  int tests = 0, fails = 0;
  id_ex_reg #(.FLUSH_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(addr), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd), .reg_wen_i(wen), .hold_flag_i(hold), .jump_en_i(jump),
    .inst_o(inst_o[0]), .inst_addr_o(addr_o[0]), .op1_o(op1_o[0]), .op2_o(op2_o[0]),
    .rd_addr_o(rd_o[0]), .reg_wen_o(wen_o[0]), .valid_o(valid_o[0]), .flushing_o(fl_o[0]),
    .bubble_cnt_o(b0));
  id_ex_reg #(.FLUSH_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(addr), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd), .reg_wen_i(wen), .hold_flag_i(hold), .jump_en_i(jump),
    .inst_o(inst_o[1]), .inst_addr_o(addr_o[1]), .op1_o(op1_o[1]), .op2_o(op2_o[1]),
    .rd_addr_o(rd_o[1]), .reg_wen_o(wen_o[1]), .valid_o(valid_o[1]), .flushing_o(fl_o[1]),
    .bubble_cnt_o(b1));
  id_ex_reg #(.FLUSH_CYCLES(1), .CNT_W(4)) uw (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(addr), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd), .reg_wen_i(wen), .hold_flag_i(hold), .jump_en_i(jump),
    .inst_o(inst_o[2]), .inst_addr_o(addr_o[2]), .op1_o(op1_o[2]), .op2_o(op2_o[2]),
    .rd_addr_o(rd_o[2]), .reg_wen_o(wen_o[2]), .valid_o(valid_o[2]), .flushing_o(fl_o[2]),
    .bubble_cnt_o(b2));
  task automatic chk(string nm, logic [151:0] a, logic [151:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  typedef struct {
    logic [31:0] inst, addr, op1, op2;
    logic [4:0] rd;
    logic wen, valid;
    int bcnt, rem;
  } m_t;
  m_t m[3];
  int fc[3] = '{1, 3, 1};
  int md[3] = '{65536, 65536, 16};
  bit armed = 0;
  function automatic m_t step(m_t s, int f, int mo);
    m_t n = s;
    if (!rst) n = '{N, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 0, 0};
    else if (jump || s.rem > 0) begin
      n = '{N, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, (s.bcnt + 1) % mo, jump ? f - 1 : s.rem - 1};
    end else if (!hold) begin
      n = '{inst, addr, op1, op2, rd, wen, 1'b1, s.bcnt, 0};
    end
    return n;
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) m[k] <= step(m[k], fc[k], md[k]);
    if (!rst) armed <= 1;
  end
  function automatic logic [151:0] act(int k);
    logic [15:0] b = k == 0 ? b0 : k == 1 ? b1 : {12'd0, b2};
    return {inst_o[k], addr_o[k], op1_o[k], op2_o[k], rd_o[k], wen_o[k], valid_o[k], fl_o[k], b};
  endfunction
  function automatic logic [151:0] expv(int k);
    return {m[k].inst, m[k].addr, m[k].op1, m[k].op2, m[k].rd, m[k].wen, m[k].valid,
            m[k].rem > 0, 16'(m[k].bcnt)};
  endfunction
  always @(negedge clk)
    if (armed)
      for (int k = 0; k < 3; k++) chk($sformatf("model_u%0d", k), act(k), expv(k));
  typedef struct {
    bit r, j, h;
    logic [31:0] i, a, o2;
    logic [4:0] d;
    bit w;
    logic [31:0] ei, eo2;
    logic [4:0] ed;
    bit ew, ev, ef;
    logic [15:0] eb;
  } vec_t;
  vec_t v[20];
  initial begin
    rst = 0; jump = 0; hold = 0; inst = 0; addr = 0; op1 = 0; op2 = 0; rd = 0; wen = 0;
    v[0]  = '{0,0,0, 32'h0,0,0,5'd0,0, N,0,5'd0,0,0,0,16'd0};
    v[1]  = '{0,0,0, 32'h0,0,0,5'd0,0, N,0,5'd0,0,0,0,16'd0};
    v[2]  = '{1,0,0, 32'h00500093,4,5,5'd1,1, 32'h00500093,5,5'd1,1,1,0,16'd0};
    v[3]  = '{1,0,0, A,8,10,5'd2,1, A,10,5'd2,1,1,0,16'd0};
    v[4]  = '{1,0,1, B,12,11,5'd3,1, A,10,5'd2,1,1,0,16'd0};
    v[5]  = '{1,0,1, B,12,11,5'd3,1, A,10,5'd2,1,1,0,16'd0};
    v[6]  = '{1,0,1, B,12,11,5'd3,1, A,10,5'd2,1,1,0,16'd0};
    v[7]  = '{1,0,0, B,12,11,5'd3,1, B,11,5'd3,1,1,0,16'd0};
    v[8]  = '{1,1,0, C,16,12,5'd4,1, N,0,5'd0,0,0,1,16'd1};
    v[9]  = '{1,0,0, C,16,12,5'd4,1, N,0,5'd0,0,0,1,16'd2};
    v[10] = '{1,0,0, C,16,12,5'd4,1, N,0,5'd0,0,0,0,16'd3};
    v[11] = '{1,0,0, C,16,12,5'd4,1, C,12,5'd4,1,1,0,16'd3};
    v[12] = '{1,1,1, D,20,13,5'd5,1, N,0,5'd0,0,0,1,16'd4};
    v[13] = '{1,1,0, D,20,13,5'd5,1, N,0,5'd0,0,0,1,16'd5};
    v[14] = '{1,0,0, D,20,13,5'd5,1, N,0,5'd0,0,0,1,16'd6};
    v[15] = '{1,0,1, D,20,13,5'd5,1, N,0,5'd0,0,0,0,16'd7};
    v[16] = '{1,0,0, D,20,13,5'd5,1, D,13,5'd5,1,1,0,16'd7};
    v[17] = '{1,1,0, E,24,14,5'd6,1, N,0,5'd0,0,0,1,16'd8};
    v[18] = '{0,0,0, E,24,14,5'd6,1, N,0,5'd0,0,0,0,16'd0};
    v[19] = '{1,0,0, E,24,14,5'd6,1, E,14,5'd6,1,1,0,16'd0};
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rst = v[n].r; jump = v[n].j; hold = v[n].h; inst = v[n].i; addr = v[n].a;
      op1 = 0; op2 = v[n].o2; rd = v[n].d; wen = v[n].w;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", n), {inst_o[1], op2_o[1], rd_o[1], wen_o[1], valid_o[1], fl_o[1], b1},
          {v[n].ei, v[n].eo2, v[n].ed, v[n].ew, v[n].ev, v[n].ef, v[n].eb});
    end
    @(negedge clk); rst = 0; jump = 0; hold = 0;
    @(negedge clk); rst = 1; jump = 1;
    @(posedge clk); #1;
    chk("fc1_bubble", {inst_o[0], valid_o[0], fl_o[0], b0}, {N, 1'b0, 1'b0, 16'd1});
    @(negedge clk); jump = 0; inst = A;
    @(posedge clk); #1;
    chk("fc1_recover", {inst_o[0], valid_o[0], b0}, {A, 1'b1, 16'd1});
    for (int n = 0; n < 16; n++) begin
      @(negedge clk); jump = 1;
    end
    @(posedge clk); #1;
    chk("wrap_cnt4", {12'd0, b2}, 16'd1);
    chk("fc1_cnt17", b0, 16'd17);
    @(negedge clk); jump = 0;
    repeat (400) begin
      @(negedge clk);
      rst  = $urandom_range(0, 49) != 0;
      jump = $urandom_range(0, 4) == 0;
      hold = $urandom_range(0, 2) == 0;
      inst = $urandom; addr = $urandom; op1 = $urandom; op2 = $urandom;
      rd = 5'($urandom); wen = 1'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
